// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column per scan tick, samples the
// synchronized rows into a 16-bit snapshot and debounces single-key presses/releases.
module keypad_scanner #(
    parameter int SCAN_DIV       = 4096,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int CNT_W = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               DEB_ONE  = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

    function automatic logic [4:0] count_ones(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
        return n;
    endfunction

    function automatic logic [3:0] key_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
        return idx;
    endfunction

    logic [3:0]       row_p0, row_p1;
    logic [PRE_W-1:0] presc;
    logic             tick;
    logic [1:0]       col_idx;
    logic [15:0]      snap, snap_full;
    logic             scan_done;
    logic [4:0]       snap_cnt;
    logic             snap_single;
    logic [3:0]       snap_key;

    state_t           state, state_nx;
    logic [3:0]       cand, cand_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [3:0]       code_nx;
    logic             valid_nx, held_nx;

    // Stage p0/p1: row synchronizer, then prescaler, column walk and snapshot capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_p0  <= 4'hF;
            row_p1  <= 4'hF;
            presc   <= '0;
            col_idx <= '0;
            snap    <= '0;
        end else begin
            row_p0 <= row;
            row_p1 <= row_p0;
            presc  <= tick ? '0 : presc + PRE_W'(1);
            if (tick) begin
                snap    <= snap_full;
                col_idx <= col_idx + 2'd1;
            end
        end
    end

    assign tick = (presc == PRE_LAST);

    always_comb begin
        col          = 4'hF;
        col[col_idx] = 1'b0;
    end

    // The snapshot including the column being sampled right now, so the FSM sees all 16 bits on the tick
    always_comb begin
        snap_full = snap;
        for (int r = 0; r < 4; r++) snap_full[{2'(r), col_idx}] = ~row_p1[r];
    end

    assign scan_done   = tick && (col_idx == 2'd3);
    assign snap_cnt    = count_ones(snap_full);
    assign snap_single = (snap_cnt == 5'd1);
    assign snap_key    = key_index(snap_full);
    assign cnt_inc     = cnt + CNT_ONE;

    // Stage p2: debounce FSM and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nx;
            cand      <= cand_nx;
            cnt       <= cnt_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_held  <= held_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        code_nx  = key_code;
        valid_nx = 1'b0;
        held_nx  = key_held;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (snap_single) begin
                        if (DEB_ONE) begin
                            code_nx  = snap_key;
                            valid_nx = 1'b1;
                            held_nx  = 1'b1;
                            state_nx = PRESSED;
                        end else begin
                            cand_nx  = snap_key;
                            cnt_nx   = CNT_ONE;
                            state_nx = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (snap_single && snap_key == cand) begin
                        if (cnt_inc == CNT_DONE) begin
                            code_nx  = cand;
                            valid_nx = 1'b1;
                            held_nx  = 1'b1;
                            state_nx = PRESSED;
                        end else begin
                            cnt_nx = cnt_inc;
                        end
                    end else if (snap_single) begin
                        cand_nx = snap_key;
                        cnt_nx  = CNT_ONE;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                PRESSED: begin
                    if (!(snap_single && snap_key == key_code)) begin
                        if (DEB_ONE) begin
                            held_nx  = 1'b0;
                            state_nx = IDLE;
                        end else begin
                            cnt_nx   = CNT_ONE;
                            state_nx = DEB_RELEASE;
                        end
                    end
                end
                DEB_RELEASE: begin
                    if (snap_single && snap_key == key_code) begin
                        state_nx = PRESSED;
                    end else if (cnt_inc == CNT_DONE) begin
                        held_nx  = 1'b0;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives the rows from col and a pressed-key mask,
// and an edge-by-edge reference model predicts every output cycle.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int SCAN     = 4 * SCAN_DIV;
    localparam int LAT      = (DEB + 1) * 4 * SCAN_DIV + 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = 16'h0000;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Reference model state
    int          m_e = 0;
    logic [15:0] m_h1 = '0, m_h2 = '0, m_snap = '0;
    bit          m_held = 1'b0;
    bit          m_valid = 1'b0;
    logic [3:0]  m_code = '0;
    logic [3:0]  m_col = 4'b1110;
    int          m_last = 0, m_run = 0, m_miss = 0;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Keypad physics: a row reads low when a pressed key in it sits on the driven column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference: rows seen by a column sample are those two edges old
    task automatic model_edge();
        logic [15:0] past;
        int c, k, n;
        past = m_h2;
        m_h2 = m_h1;
        m_h1 = pressed;
        m_valid = 1'b0;
        if (!rst_n) begin
            m_e = 0; m_snap = '0; m_held = 1'b0; m_code = '0;
            m_run = 0; m_miss = 0; m_last = 0;
        end else begin
            m_e++;
            if (m_e % SCAN_DIV == 0) begin
                c = (m_e / SCAN_DIV - 1) % 4;
                for (int r = 0; r < 4; r++) m_snap[r*4+c] = past[r*4+c];
                if (c == 3) begin
                    n = $countones(m_snap);
                    k = 0;
                    for (int b = 0; b < 16; b++) if (m_snap[b]) k = b;
                    if (!m_held) begin
                        if (n == 1) begin
                            if (m_run > 0 && k == m_last) m_run++;
                            else begin m_run = 1; m_last = k; end
                        end else begin
                            m_run = 0;
                        end
                        if (m_run == DEB) begin
                            m_held = 1'b1; m_code = 4'(k); m_valid = 1'b1; m_run = 0;
                        end
                    end else begin
                        if (n == 1 && k == int'(m_code)) m_miss = 0;
                        else begin
                            m_miss++;
                            if (m_miss == DEB) begin m_held = 1'b0; m_miss = 0; end
                        end
                    end
                end
            end
        end
        m_col = 4'hF;
        m_col[(m_e / SCAN_DIV) % 4] = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk("col", 32'(col), 32'(m_col));
            chk("key_valid", 32'(key_valid), 32'(m_valid));
            chk("key_held", 32'(key_held), 32'(m_held));
            chk("key_code", 32'(key_code), 32'(m_code));
            if (key_valid) pulses++;
        end
    endtask

    initial begin
        int k, sel, hold;

        // Reset and scan sequence
        rst_n = 1'b0;
        step(3);
        chk("rst_col", 32'(col), 32'h0000_000E);
        chk("rst_valid", 32'(key_valid), 32'h0);
        chk("rst_held", 32'(key_held), 32'h0);
        chk("rst_code", 32'(key_code), 32'h0);
        rst_n = 1'b1;
        step(4);  chk("scan_c1", 32'(col), 32'h0000_000D);
        step(4);  chk("scan_c2", 32'(col), 32'h0000_000B);
        step(4);  chk("scan_c3", 32'(col), 32'h0000_0007);
        step(4);  chk("scan_c0", 32'(col), 32'h0000_000E);

        // Clean press of key 9, then a long hold
        pressed = 16'h0200;
        pulses = 0;
        step(LAT + 3);
        chk("press_pulses", 32'(pulses), 32'd1);
        chk("press_code", 32'(key_code), 32'd9);
        chk("press_held", 32'(key_held), 32'd1);
        pulses = 0;
        step(20 * SCAN);
        chk("hold_pulses", 32'(pulses), 32'd0);
        chk("hold_held", 32'(key_held), 32'd1);

        // Release: held persists until three misses have been seen
        pressed = 16'h0000;
        step(2 * SCAN);
        chk("rel_early_held", 32'(key_held), 32'd1);
        step(LAT);
        chk("rel_held", 32'(key_held), 32'd0);
        chk("rel_code", 32'(key_code), 32'd9);

        // Bounce at a 12-clock toggle never yields three matching snapshots
        pulses = 0;
        step($urandom_range(0, 23));
        for (int t = 0; t < 7; t++) begin
            pressed = pressed ^ 16'h0200;
            step(12);
        end
        pressed = 16'h0000;
        step(6 * SCAN);
        chk("bounce_pulses", 32'(pulses), 32'd0);
        chk("bounce_held", 32'(key_held), 32'd0);

        // Two keys together are ignored; the survivor is accepted on its own
        pressed = 16'h8001;
        step(6 * SCAN);
        chk("multi_pulses", 32'(pulses), 32'd0);
        chk("multi_held", 32'(key_held), 32'd0);
        pressed = 16'h8000;
        step(LAT + 3);
        chk("multi_rel_pulses", 32'(pulses), 32'd1);
        chk("multi_rel_code", 32'(key_code), 32'd15);
        pressed = 16'h0000;
        step(6 * SCAN);

        // One-scan dropout while held is absorbed
        pressed = 16'h0200;
        step(LAT + 3);
        chk("drop_pre_held", 32'(key_held), 32'd1);
        pulses = 0;
        pressed = 16'h0000;
        step(SCAN);
        pressed = 16'h0200;
        step(5 * SCAN);
        chk("drop_pulses", 32'(pulses), 32'd0);
        chk("drop_held", 32'(key_held), 32'd1);

        // Reset while pressed, then re-acceptance of the still-held key
        rst_n = 1'b0;
        step(1);
        chk("midrst_held", 32'(key_held), 32'd0);
        chk("midrst_code", 32'(key_code), 32'd0);
        chk("midrst_col", 32'(col), 32'h0000_000E);
        chk("midrst_valid", 32'(key_valid), 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        step(LAT + 3);
        chk("reacc_pulses", 32'(pulses), 32'd1);
        chk("reacc_code", 32'(key_code), 32'd9);
        pressed = 16'h0000;
        step(6 * SCAN);

        // Random single key press
        k = $urandom_range(0, 15);
        pressed = 16'(1 << k);
        pulses = 0;
        step(LAT + 3);
        chk("rnd_pulses", 32'(pulses), 32'd1);
        chk("rnd_code", 32'(key_code), 32'(k));
        pressed = 16'h0000;
        step(6 * SCAN);

        // Random soak against the reference model
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) pressed = 16'h0000;
            else if (sel < 8) pressed = 16'(1 << $urandom_range(0, 15));
            else pressed = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
            hold = $urandom_range(5, 130);
            step(hold);
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
